// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divider (DIV / DIVU / REM / REMU).
//
// Uses a radix-2 restoring algorithm that produces one quotient bit per clock.
// Division by zero and signed overflow (most-negative / -1) finish immediately
// without iterating. busy is high from the cycle after a request is accepted
// through the writeback cycle, so the core can stall around it.
//
// Ports:
//   clk         core clock, rising-edge active
//   rst         asynchronous reset, active-low
//   start       request, sampled only while idle
//   op          00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   rs1_data    dividend
//   rs2_data    divisor
//   rd_addr_in  destination register, captured together with start
//   kill        abort the current operation, no writeback
//   busy        high whenever an operation is in flight (including writeback)
//   rd_write    one-cycle register-file write strobe (suppressed for x0)
//   rd_addr     captured destination register
//   rd_data     result, valid while rd_write is high
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr_in,
   input  logic            kill,
   output logic            busy,
   output logic            rd_write,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_data
);

   localparam int CNT_W = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Two's-complement negation, wrapping modulo 2^XLEN.
   function automatic logic [XLEN-1:0] neg_wrap(input logic [XLEN-1:0] v);
      return ~v + XLEN'(1);
   endfunction

   // Magnitude of a signed operand; the most-negative value maps onto itself,
   // which is still the correct unsigned magnitude.
   function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
      return (v < 0) ? neg_wrap(v) : v;
   endfunction

   // Pick quotient or remainder and apply the recorded result signs.
   function automatic logic [XLEN-1:0] sel_result(
      input logic            is_rem,
      input logic [XLEN-1:0] q,
      input logic [XLEN-1:0] r,
      input logic            q_neg,
      input logic            r_neg
   );
      logic [XLEN-1:0] res;
      if (is_rem) res = r_neg ? neg_wrap(r) : r;
      else        res = q_neg ? neg_wrap(q) : q;
      return res;
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   quot_q, quot_d;
   logic [XLEN-1:0]   dvsr_q, dvsr_d;
   logic [1:0]        op_q, op_d;
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;
   logic [4:0]        rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]   rd_data_q, rd_data_d;

   logic signed [XLEN-1:0] rs1_s;
   logic signed [XLEN-1:0] rs2_s;
   logic                   req_signed;
   logic                   req_is_rem;
   logic                   div_zero;
   logic                   div_ovf;
   logic [XLEN:0]          rem_sh;
   logic signed [XLEN:0]   trial;
   logic                   trial_neg;
   logic [XLEN-1:0]        rem_step;
   logic [XLEN-1:0]        quot_step;

   assign rs1_s      = rs1_data;
   assign rs2_s      = rs2_data;
   assign req_signed = ~op[0];
   assign req_is_rem = op[1];
   assign div_zero   = (rs2_data == '0);
   assign div_ovf    = req_signed
                       && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                       && (rs2_data == '1);

   // One restoring step: shift {rem, quot} left, try to subtract the divisor.
   // The partial remainder is always below the divisor, so the shifted value
   // fits in XLEN+1 bits and bit XLEN of the difference is its sign.
   always_comb begin
      rem_sh    = {rem_q, quot_q[XLEN-1]};
      trial     = $signed(rem_sh - {1'b0, dvsr_q});
      trial_neg = trial[XLEN];
      rem_step  = trial_neg ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
      quot_step = {quot_q[XLEN-2:0], ~trial_neg};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      dvsr_d    = dvsr_q;
      op_d      = op_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;

      case (state_q)
         S_IDLE: begin
            // kill outranks start: nothing is captured on a killed request.
            if (start && !kill) begin
               op_d      = op;
               rd_addr_d = rd_addr_in;
               if (div_zero) begin
                  rd_data_d = req_is_rem ? rs1_data : '1;
                  state_d   = S_DONE;
               end else if (div_ovf) begin
                  rd_data_d = req_is_rem ? '0 : rs1_data;
                  state_d   = S_DONE;
               end else begin
                  state_d = S_CALC;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quot_d  = req_signed ? abs_val(rs1_s) : rs1_data;
                  dvsr_d  = req_signed ? abs_val(rs2_s) : rs2_data;
                  q_neg_d = req_signed && (rs1_s[XLEN-1] ^ rs2_s[XLEN-1]);
                  r_neg_d = req_signed && rs1_s[XLEN-1];
               end
            end
         end

         S_CALC: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               rem_d  = rem_step;
               quot_d = quot_step;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) begin
                  state_d   = S_DONE;
                  rd_data_d = sel_result(op_q[1], quot_step, rem_step,
                                         q_neg_q, r_neg_q);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         dvsr_q    <= '0;
         op_q      <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         dvsr_q    <= dvsr_d;
         op_q      <= op_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   // Writes to x0 are dropped, and a kill in the writeback cycle cancels it.
   assign rd_write = (state_q == S_DONE) && (rd_addr_q != 5'd0) && !kill;
   assign rd_addr  = rd_addr_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit.
// A cycle-count model predicts busy/rd_write/rd_addr/rd_data every cycle from
// plain integer division; directed vectors pin the model with literal results.
module tb_div_unit;

   localparam int XLEN = 32;
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  rd_in = '0;
   logic        busy;
   logic        rd_write;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;

   int total = 0;
   int bad = 0;

   div_unit #(.XLEN(XLEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op         (op),
      .rs1_data   (rs1),
      .rs2_data   (rs2),
      .rd_addr_in (rd_in),
      .kill       (kill),
      .busy       (busy),
      .rd_write   (rd_write),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
      case (o)
         OP_DIV:  return sa / sb;
         OP_DIVU: return a / b;
         OP_REM:  return sa % sb;
         default: return a % b;
      endcase
   endfunction

   // m_left = cycles still to be spent busy; 1 means the writeback cycle.
   int          m_left = 0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   logic [31:0] m_res = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_left = 0;
         m_addr = '0;
         m_data = '0;
      end else if (m_left == 0) begin
         if (start && !kill) begin
            m_addr = rd_in;
            m_res  = ref_result(op, rs1, rs2);
            m_left = special(op, rs1, rs2) ? 1 : XLEN + 1;
            if (m_left == 1) m_data = m_res;
         end
      end else if (kill) begin
         m_left = 0;
      end else begin
         m_left = m_left - 1;
         if (m_left == 1) m_data = m_res;
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(m_left != 0));
      check("rd_write", 32'(rd_write), 32'((m_left == 1) && (m_addr != 5'd0) && !kill));
      check("rd_addr", 32'(rd_addr), 32'(m_addr));
      check("rd_data", rd_data, m_data);
   end

   // ---------------- directed stimulus ----------------
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      @(posedge clk); #2;
      start = 1'b1; op = o; rs1 = a; rs2 = b; rd_in = rd;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] want, input int want_lat);
      int busy_n;
      int writes;
      int lat;
      logic [31:0] got;
      logic [4:0]  got_rd;
      busy_n = 0; writes = 0; lat = 0; got = '0; got_rd = '0;
      issue(o, a, b, rd);
      for (int n = 1; n <= 45; n++) begin
         @(negedge clk);
         if (!busy) break;
         busy_n++;
         if (rd_write) begin
            writes++; lat = n; got = rd_data; got_rd = rd_addr;
         end
      end
      check({name, " busy_cycles"}, 32'(busy_n), 32'(want_lat));
      check({name, " writes"}, 32'(writes), 32'(rd != 5'd0));
      if (rd != 5'd0) begin
         check({name, " latency"}, 32'(lat), 32'(want_lat));
         check({name, " data"}, got, want);
         check({name, " rd"}, 32'(got_rd), 32'(rd));
      end
   endtask

   initial begin
      int writes;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset rd_write", 32'(rd_write), 32'd0);
      check("reset rd_data", rd_data, 32'd0);
      check("reset rd_addr", 32'(rd_addr), 32'd0);
      rst = 1'b1;

      run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
      run("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33);
      run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
      run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
      run("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 33);
      run("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd10, 32'hFFFF_FFF2, 33);
      run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
      run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);
      run("divu_by0", OP_DIVU, 32'd123, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
      run("remu_by0", OP_REMU, 32'd123, 32'd0, 5'd14, 32'd123, 1);
      run("div_m5_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd15, 32'hFFFF_FFFF, 1);
      run("rem_m5_by0", OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd16, 32'hFFFF_FFFB, 1);
      run("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd17, 32'hFFFF_FFFF, 33);
      run("divu_80_ff", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 33);
      run("div_20_4_x0", OP_DIV, 32'd20, 32'd4, 5'd0, 32'd5, 33);

      // kill at CALC step 10
      issue(OP_DIV, 32'd50, 32'd5, 5'd3);
      repeat (9) @(posedge clk);
      #2 kill = 1'b1;
      @(posedge clk); #2 kill = 1'b0;
      @(negedge clk);
      check("kill_calc busy", 32'(busy), 32'd0);
      run("divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33);

      // kill and start together while idle: not accepted
      @(posedge clk); #2;
      start = 1'b1; kill = 1'b1; op = OP_DIVU; rs1 = 32'd8; rs2 = 32'd2; rd_in = 5'd20;
      @(posedge clk); #2;
      start = 1'b0; kill = 1'b0;
      @(negedge clk);
      check("kill_idle busy", 32'(busy), 32'd0);
      check("kill_idle rd_addr", 32'(rd_addr), 32'd4);

      // kill in the writeback cycle
      issue(OP_DIVU, 32'd123, 32'd0, 5'd21);
      kill = 1'b1;
      @(negedge clk);
      check("kill_done rd_write", 32'(rd_write), 32'd0);
      check("kill_done busy", 32'(busy), 32'd1);
      @(posedge clk); #2 kill = 1'b0;
      @(negedge clk);
      check("kill_done idle", 32'(busy), 32'd0);

      // start held through busy: one result per acceptance
      @(posedge clk); #2;
      start = 1'b1; op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd9;
      writes = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (rd_write) writes++;
      end
      check("held first window writes", 32'(writes), 32'd1);
      @(posedge clk); #2 start = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (rd_write) writes++;
         if (!busy) break;
      end
      check("held drained", 32'(busy), 32'd0);
      check("held total writes", 32'(writes), 32'd2);

      // asynchronous reset mid-CALC
      issue(OP_DIVU, 32'd100, 32'd7, 5'd5);
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_rst busy", 32'(busy), 32'd0);
      check("async_rst rd_write", 32'(rd_write), 32'd0);
      check("async_rst rd_data", rd_data, 32'd0);
      check("async_rst rd_addr", 32'(rd_addr), 32'd0);
      @(negedge clk); #1 rst = 1'b1;
      run("after_rst_divu_9_3", OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider for DIV/DIVU/REM/REMU.
- Consumes the operand pair read from the register file and writes its result back through the register file write port.
- Holds busy high while working so the core control can stall the PC and block other writebacks.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
start  input  1  request; sampled only in IDLE
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
rs1_data  input  XLEN  dividend
rs2_data  input  XLEN  divisor
rd_addr_in  input  5  destination register, captured with start
kill  input  1  abort current operation (trap/flush); no writeback
busy  output  1  high whenever state != IDLE
rd_write  output  1  one-cycle writeback strobe to register file
rd_addr  output  5  captured destination
rd_data  output  XLEN  result, valid when rd_write=1

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low.
- Reset (rst=0), immediate regardless of state:
  - state=IDLE; busy=0, rd_write=0, rd_addr=0, rd_data=0.
  - All internal registers cleared.
  - Reset mid-operation discards the operation; no write is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=0: stay in IDLE.
  - start=1: capture op and rd_addr_in, evaluate special cases, then:
    - Divisor == 0: go to DONE with result = all ones (DIV/DIVU) or the dividend unchanged (REM/REMU).
    - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: go to DONE with result = 0x80000000 (DIV) or 0 (REM).
    - Otherwise: go to CALC, counter=0, partial remainder=0.
    - For signed ops, load operand magnitudes (two's-complement absolute value) and record q_neg = sign(rs1) XOR sign(rs2) and r_neg = sign(rs1).
- CALC, one step per cycle:
  - Shift {rem, quot} left by 1.
  - trial = rem_shifted - divisor, computed at XLEN+1 bits.
  - If trial is non-negative: rem = trial and quot LSB = 1; else keep rem and quot LSB = 0.
  - Counter increments each step; after the XLEN-th step, go to DONE.
- Result selection on entry to DONE:
  - quot for DIV/DIVU, rem for REM/REMU.
  - Signed ops negate the quotient if q_neg and the remainder if r_neg.
  - rd_data registered.
- DONE:
  - rd_write=1 for exactly this one cycle, gated off when rd_addr==0.
  - busy still 1 in this cycle.
  - Next state is IDLE unconditionally.
- Latency, counted from the rising edge that samples start (E0):
  - Special case: rd_write is high in the cycle after E0.
  - Normal: rd_write is high in the cycle after edge E0+XLEN, i.e. E32 at XLEN=32.
  - busy rises in the cycle after E0.
- start while busy=1 is ignored; the core must hold it until busy=0.
- start is accepted in the same cycle busy falls: DONE→IDLE, then IDLE samples the next start.
- kill=1 in CALC or DONE: next state IDLE, rd_write forced 0 that same cycle, result discarded.
  - kill in IDLE has priority over start; no capture.
- rd_data and rd_addr hold their last value between writes.
- Unsigned ops never negate.
- All arithmetic wraps modulo 2^XLEN.

Test Plan:
- DIVU 100/7, rd=5, start at E0 -> busy for 33 cycles; rd_write high once in the cycle after E32 with rd_addr=5, rd_data=14.
- DIV -7/2, then REM -7/2 -> rd_data 0xFFFFFFFD (-3), then 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIV 0x80000000/0xFFFFFFFF -> rd_data 0x80000000 one cycle after E0; REM of the same operands -> 0.
- DIVU 123/0 -> 0xFFFFFFFF; REMU 123/0 -> 123; both with latency 1.
- kill asserted at CALC step 10 of a DIV 50/5 -> no rd_write; busy 0 next cycle; a following start of DIVU 9/3 -> 3.
- rst=0 pulse mid-CALC -> busy, rd_write, rd_data all 0 immediately with no clock edge; DIV 20/4 with rd=0 -> busy sequence normal, rd_write stays 0; start held during busy -> no second result until re-accepted.
